dual_issue_unit: RTL

Front end of the two-lane core. Accepts fetched instruction pairs into a small in-order instruction queue. Each cycle it issues either one instruction (lane 0) or two instructions (lane 0 + lane 1). An instruction goes to lane 1 only when it is independent of the lane-0 instruction. It drives the `op`/`funct3`/`funct7b5` decode fields that the two per-lane controllers consume.

---
 rtl/superscalar_pkg.sv | 43 ++++
 rtl/issue_pair_check.sv | 34 +++
 rtl/dual_issue_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/superscalar_pkg.sv
// rtl/superscalar_pkg.sv - opcodes, NOP and queue entry type shared by the dual-issue front end
package superscalar_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int IQ_XLEN = 32;

  typedef struct packed {
    logic [31:0]        instr;
    logic [IQ_XLEN-1:0] pc;
  } iq_entry_t;

  function automatic logic writes_rd(input logic [6:0] op);
    return op inside {OP_RTYPE, OP_ITYPE, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    return op inside {OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return op inside {OP_RTYPE, OP_STORE, OP_BRANCH};
  endfunction

  function automatic logic is_mem(input logic [6:0] op);
    return op inside {OP_LOAD, OP_STORE};
  endfunction

  function automatic logic is_ctrl(input logic [6:0] op);
    return op inside {OP_BRANCH, OP_JAL, OP_JALR};
  endfunction

endpackage

// File: rtl/issue_pair_check.sv
// rtl/issue_pair_check.sv - decides whether the younger instruction may issue alongside the older one
module issue_pair_check
  import superscalar_pkg::*;
(
  input  logic [31:0] instr0,
  input  logic [31:0] instr1,
  output logic        pairable
);

  logic [6:0] opc0, opc1;
  logic [4:0] rd0, rd1, rs1_1, rs2_1;
  logic       rd0_live, ctrl0, mem_pair, raw, waw;
  logic       unused_bits;

  assign opc0  = instr0[6:0];
  assign opc1  = instr1[6:0];
  assign rd0   = instr0[11:7];
  assign rd1   = instr1[11:7];
  assign rs1_1 = instr1[19:15];
  assign rs2_1 = instr1[24:20];

  // x0 is never a real destination, so it cannot create a dependency
  assign rd0_live = writes_rd(opc0) && (rd0 != 5'd0);
  assign ctrl0    = is_ctrl(opc0);
  assign mem_pair = is_mem(opc0) && is_mem(opc1);
  assign raw      = rd0_live && ((reads_rs1(opc1) && (rs1_1 == rd0)) ||
                                 (reads_rs2(opc1) && (rs2_1 == rd0)));
  assign waw      = rd0_live && writes_rd(opc1) && (rd1 == rd0);

  assign pairable = !(ctrl0 || mem_pair || raw || waw);

  assign unused_bits = ^{instr0[31:12], instr1[31:25], instr1[14:12]};

endmodule

// File: rtl/dual_issue_unit.sv
// rtl/dual_issue_unit.sv - instruction queue with one/two-wide in-order issue; DUAL_ISSUE_EN enables lane 1
module dual_issue_unit
  import superscalar_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int XLEN   = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_valid,
  output logic            fetch_ready,
  input  logic [31:0]     fetch_instr0,
  input  logic [31:0]     fetch_instr1,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            flush,
  input  logic            issue_ready,
  output logic            lane0_valid,
  output logic            lane1_valid,
  output logic [31:0]     lane0_instr,
  output logic [31:0]     lane1_instr,
  output logic [XLEN-1:0] lane0_pc,
  output logic [XLEN-1:0] lane1_pc,
  output logic [6:0]      op0,
  output logic [6:0]      op1,
  output logic [2:0]      funct3_0,
  output logic [2:0]      funct3_1,
  output logic            funct7b5_0,
  output logic            funct7b5_1
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [31:0]     q_instr [QDEPTH];
  logic [XLEN-1:0] q_pc    [QDEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr1;
  logic [CW-1:0] count;
  logic          push;
  logic [1:0]    pop_n;

  assign wr_ptr1 = wr_ptr + 1'b1;

  // Only the registered count is used, so a same-cycle pop never frees room early
  assign fetch_ready = reset && !flush && (count <= CW'(QDEPTH - 2));
  assign push        = fetch_valid && fetch_ready;
  assign lane0_valid = (count != '0) && !flush;

`ifdef DUAL_ISSUE_EN
  logic [PW-1:0] rd_ptr1;
  logic          pairable;

  assign rd_ptr1 = rd_ptr + 1'b1;

  issue_pair_check u_pair_check (
    .instr0   (q_instr[rd_ptr]),
    .instr1   (q_instr[rd_ptr1]),
    .pairable (pairable)
  );

  assign lane1_valid = lane0_valid && (count >= CW'(2)) && pairable;
  assign lane1_instr = lane1_valid ? q_instr[rd_ptr1] : NOP_INSTR;
  assign lane1_pc    = lane1_valid ? q_pc[rd_ptr1]    : '0;
`else
  assign lane1_valid = 1'b0;
  assign lane1_instr = NOP_INSTR;
  assign lane1_pc    = '0;
`endif

  assign pop_n = (issue_ready && lane0_valid) ? (lane1_valid ? 2'd2 : 2'd1) : 2'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + (push ? PW'(2) : PW'(0));
      rd_ptr <= rd_ptr + PW'(pop_n);
      count  <= count + (push ? CW'(2) : CW'(0)) - CW'(pop_n);
    end
  end

  // Payload needs no reset: an entry is only read once count says it was written
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr]  <= fetch_instr0;
      q_instr[wr_ptr1] <= fetch_instr1;
      q_pc[wr_ptr]     <= fetch_pc;
      q_pc[wr_ptr1]    <= fetch_pc + XLEN'(4);
    end
  end

  assign lane0_instr = lane0_valid ? q_instr[rd_ptr] : NOP_INSTR;
  assign lane0_pc    = lane0_valid ? q_pc[rd_ptr]    : '0;

  assign op0        = lane0_instr[6:0];
  assign funct3_0   = lane0_instr[14:12];
  assign funct7b5_0 = lane0_instr[30];
  assign op1        = lane1_instr[6:0];
  assign funct3_1   = lane1_instr[14:12];
  assign funct7b5_1 = lane1_instr[30];

endmodule
